// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the wait-state memory responder.
// Used by mem_resp_array and mem_responder.
package mem_resp_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Unsigned range check; no wrap, so 16'hFFFF is never in range
  function automatic logic addr_in_range(
    input logic [ADDR_W-1:0] a,
    input int unsigned       depth
  );
    return 32'(a) < depth;
  endfunction

endpackage

// File: rtl/mem_resp_array.sv
// Word storage for mem_responder: synchronous write, combinational
// read at the index of the transaction being served. Not reset.
module mem_resp_array
  import mem_resp_pkg::*;
#(
  parameter int DEPTH = 101,
  parameter int IDX_W = 7
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Commit a store on the clock edge the responder enters RESP
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[idx] <= wdata;
    end
  end

  assign rdata = mem_q[idx];

endmodule

// File: rtl/mem_responder.sv
// Single-port memory responder with req/ack handshake and optional
// wait states (enabled by defining MEM_RESPONDER_WAIT_EN).
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int DEPTH       = 101,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

`ifdef MEM_RESPONDER_WAIT_EN
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
  logic [3:0] cnt_q, cnt_d;
`else
  logic unused_wait_cfg;
  assign unused_wait_cfg = ^4'(WAIT_CYCLES);
`endif

  logic [ADDR_W-1:0] t_addr;
  logic              t_we;
  logic [DATA_W-1:0] t_wdata;
  logic              t_hit;
  logic [IDX_W-1:0]  t_idx;
  logic              enter_resp;
  logic              mem_we;
  logic [DATA_W-1:0] arr_rdata;

  // Transaction view: live inputs in IDLE, captured copy afterwards
  always_comb begin
    t_addr  = addr_q;
    t_we    = we_q;
    t_wdata = wdata_q;
    if (state_q == IDLE) begin
      t_addr  = addr;
      t_we    = we;
      t_wdata = wdata;
    end
  end

  assign t_hit = addr_in_range(t_addr, DEPTH);
  assign t_idx = t_hit ? t_addr[IDX_W-1:0] : '0;

  // Next-state and registered-output computation
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
`ifdef MEM_RESPONDER_WAIT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req) begin
          addr_d  = addr;
          we_d    = we;
          wdata_d = wdata;
`ifdef MEM_RESPONDER_WAIT_EN
          cnt_d   = WAIT_INIT;
          if (WAIT_INIT == 4'd0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
          end
`else
          state_d = RESP;
`endif
        end
      end
`ifdef MEM_RESPONDER_WAIT_EN
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
        end
      end
`endif
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign enter_resp = (state_d == RESP) && (state_q != RESP);
  assign mem_we     = rst_n && enter_resp && t_we && t_hit;

  // Response strobe, error flag and held read data
  always_comb begin
    ack_d   = enter_resp;
    err_d   = enter_resp && !t_hit;
    busy_d  = (state_d != IDLE);
    rdata_d = rdata_q;
    if (enter_resp) begin
      if (!t_hit) begin
        rdata_d = '0;
      end else if (!t_we) begin
        rdata_d = arr_rdata;
      end
    end
  end

  // FSM and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      rdata_q <= '0;
`ifdef MEM_RESPONDER_WAIT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      rdata_q <= rdata_d;
`ifdef MEM_RESPONDER_WAIT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  mem_resp_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .idx   (t_idx),
    .wdata (t_wdata),
    .rdata (arr_rdata)
  );

  assign ack   = ack_q;
  assign err   = err_q;
  assign busy  = busy_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench for mem_responder against a
// behavioural memory model.
module tb_mem_responder;

  localparam int DEPTH = 101;
  localparam int W     = 2;
`ifdef MEM_RESPONDER_WAIT_EN
  localparam int LAT   = W + 1;
`else
  localparam int LAT   = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic        we;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        ack;
  logic [15:0] rdata;
  logic        err;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [15:0] mem_m [DEPTH];
  logic [15:0] last_rd;

  mem_responder #(
    .DEPTH       (DEPTH),
    .WAIT_CYCLES (W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .ack   (ack),
    .rdata (rdata),
    .err   (err),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete request; inputs are scrambled once accepted
  task automatic run_txn(input logic w, input logic [15:0] a,
                         input logic [15:0] d);
    int          n;
    logic        oor;
    logic [15:0] exp_rd;
    oor = (32'(a) >= DEPTH);
    @(negedge clk);
    chk("idle_busy", 32'(busy), 0);
    req = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk); #1;
    n = 1;
    req = 1'b0; we = 1'($urandom);
    addr = 16'($urandom); wdata = 16'($urandom);
    while (!ack && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (oor)     exp_rd = 16'h0000;
    else if (!w) exp_rd = mem_m[a];
    else         exp_rd = last_rd;
    if (w && !oor) mem_m[a] = d;
    last_rd = exp_rd;
    chk("ack_seen", 32'(ack), 1);
    chk("latency", 32'(n), 32'(LAT));
    chk("err", 32'(err), 32'(oor));
    chk("rdata", 32'(rdata), 32'(exp_rd));
    @(posedge clk); #1;
    chk("ack_pulse", 32'(ack), 0);
    chk("busy_end", 32'(busy), 0);
  endtask

  initial begin
    int          t[3];
    int          n;
    int          acks;
    logic [15:0] a;
    rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    last_rd = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rdata", 32'(rdata), 0);
    rst_n = 1'b1;

    for (int i = 0; i < DEPTH; i++)
      run_txn(1'b1, 16'(i), 16'($urandom));

    run_txn(1'b1, 16'd9, 16'd3);
    run_txn(1'b0, 16'd9, 16'd0);
    run_txn(1'b1, 16'd100, 16'h1234);
    run_txn(1'b0, 16'd100, 16'd0);
    run_txn(1'b0, 16'd101, 16'd0);
    run_txn(1'b1, 16'd200, 16'd7);
    run_txn(1'b0, 16'd200, 16'd0);
    run_txn(1'b0, 16'hFFFF, 16'd0);

    // Reset aborts an in-flight store to address 20
    run_txn(1'b1, 16'd20, 16'd9);
`ifdef MEM_RESPONDER_WAIT_EN
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 16'd20; wdata = 16'd5;
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
`else
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 16'd20; wdata = 16'd5;
    rst_n = 1'b0;
`endif
    @(posedge clk); #1;
    chk("abort_ack", 32'(ack), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_rdata", 32'(rdata), 0);
    @(negedge clk);
    rst_n = 1'b1; req = 1'b0;
    last_rd = '0;
    acks = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ack) acks++;
    end
    chk("abort_no_ack", 32'(acks), 0);
    run_txn(1'b0, 16'd20, 16'd0);

    // Back-to-back reads with req held high
    run_txn(1'b1, 16'd21, 16'h0A21);
    run_txn(1'b1, 16'd22, 16'h0B22);
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 16'd20;
    for (int i = 0; i < 3; i++) begin
      n = 0;
      do begin
        @(posedge clk); #1;
        n++;
      end while (!ack && n < 40);
      chk("b2b_ack", 32'(ack), 1);
      chk("b2b_rdata", 32'(rdata), 32'(mem_m[20+i]));
      last_rd = mem_m[20+i];
      t[i] = cyc;
      if (i < 2) addr = 16'(21 + i);
      else req = 1'b0;
    end
    chk("b2b_gap0", 32'(t[1] - t[0]), 32'(LAT + 1));
    chk("b2b_gap1", 32'(t[2] - t[1]), 32'(LAT + 1));
    @(posedge clk); #1;

    for (int k = 0; k < 80; k++) begin
      case ($urandom_range(0, 5))
        0:       a = 16'(DEPTH - 1);
        1:       a = 16'(DEPTH);
        2:       a = 16'hFFFF;
        3:       a = 16'($urandom);
        default: a = 16'($urandom_range(0, DEPTH - 1));
      endcase
      run_txn(1'($urandom), a, 16'($urandom));
    end

    for (int i = 0; i < DEPTH; i++)
      run_txn(1'b0, 16'(i), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
